handshake_pipe_ready_patting: RTL and testbench

HANDSHAKE_PIPE_READY_PATTING -- requirements
Module: handshake_pipe_ready_patting

---
 rtl/handshake_pipe_ready_patting.sv | 121 ++++++++++++
 tb/tb_handshake_pipe_ready_patting.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/handshake_pipe_ready_patting.sv
// -----------------------------------------------------------------------------
// handshake_pipe_ready_patting
//
// Two-entry valid/ready pipeline stage whose upstream ready is a flop. A skid
// register catches the one beat that can arrive while master_ready is still
// high but the downstream has stalled. This removes any combinational path
// from slave_ready to master_ready.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous, active-high reset
//   master_valid : upstream beat valid
//   master_data  : upstream payload [DATA_W]
//   master_ready : stage accepts a beat (registered)
//   slave_valid  : downstream beat valid (decoded from state)
//   slave_data   : downstream payload, straight from the main register
//   slave_ready  : downstream accepts a beat
//   occupancy    : beats held (0, 1 or 2)
//   xfer_cnt     : completed downstream handshakes, wraps [CNT_W]
// -----------------------------------------------------------------------------
module handshake_pipe_ready_patting #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              master_valid,
  input  logic [DATA_W-1:0] master_data,
  output logic              master_ready,
  output logic              slave_valid,
  output logic [DATA_W-1:0] slave_data,
  input  logic              slave_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // The encoding equals the number of beats held, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic in_hs;
  logic out_hs;

  assign slave_valid  = (state_q != EMPTY);
  assign master_ready = ready_q;
  assign slave_data   = main_q;
  assign occupancy    = state_q;
  assign xfer_cnt     = cnt_q;

  assign in_hs  = master_valid & ready_q;
  assign out_hs = slave_valid & slave_ready;

  always_comb begin
    // NOTE: every next-state variable gets a hold default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + CNT_W'(out_hs);

    unique case (state_q)
      EMPTY: begin
        if (in_hs) begin
          main_d  = master_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_hs && out_hs) begin
          // Drain and refill in the same cycle: no bubble.
          main_d = master_data;
        end else if (in_hs) begin
          skid_d  = master_data;
          state_d = FULL;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is low here, so only the output side can move.
        if (out_hs) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Ready is computed from the next state and registered, so the flop
    // already reflects whether the next cycle has room.
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the values sampled at the same edge.
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_handshake_pipe_ready_patting.sv
// -----------------------------------------------------------------------------
// tb_handshake_pipe_ready_patting
//
// Drives directed and random valid/ready traffic into the stage and compares
// every output, every cycle, against a queue-based model of a two-deep FIFO.
// The counter is built 4 bits wide so wrap-around is exercised constantly.
// -----------------------------------------------------------------------------
module tb_handshake_pipe_ready_patting;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              master_valid;
  logic [DATA_W-1:0] master_data;
  logic              master_ready;
  logic              slave_valid;
  logic [DATA_W-1:0] slave_data;
  logic              slave_ready;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  xfer_cnt;

  handshake_pipe_ready_patting #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .master_valid(master_valid),
    .master_data (master_data),
    .master_ready(master_ready),
    .slave_valid (slave_valid),
    .slave_data  (slave_data),
    .slave_ready (slave_ready),
    .occupancy   (occupancy),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of held beats plus a wrapping counter.
  logic [DATA_W-1:0] m_q[$];
  int                m_cnt   = 0;
  bit                m_known = 0;  // a reset has been applied
  bit                m_zero  = 0;  // data register still holds its reset value

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
  task automatic step(input bit r, input bit mv, input logic [DATA_W-1:0] md, input bit sr);
    bit hs_in, hs_out;
    rst          = r;
    master_valid = mv;
    master_data  = md;
    slave_ready  = sr;
    #3;
    if (m_known) begin
      check("slave_valid",  64'(slave_valid),  64'(m_q.size() != 0));
      check("master_ready", 64'(master_ready), 64'(m_q.size() < 2));
      check("occupancy",    64'(occupancy),    64'(m_q.size()));
      check("xfer_cnt",     64'(xfer_cnt),     64'(m_cnt % (1 << CNT_W)));
      if (m_q.size() != 0)
        check("slave_data", 64'(slave_data), 64'(m_q[0]));
      else if (m_zero)
        check("slave_data_rst", 64'(slave_data), 64'd0);
    end
    hs_in  = mv && (m_q.size() < 2);
    hs_out = (m_q.size() != 0) && sr;
    @(posedge clk);
    #1;
    if (r) begin
      m_q.delete();
      m_cnt   = 0;
      m_known = 1;
      m_zero  = 1;
    end else if (m_known) begin
      if (hs_out) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (hs_in) begin
        m_q.push_back(md);
        m_zero = 0;
      end
    end
  endtask

  task automatic idle(input int n, input bit sr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DATA_W'($urandom), sr);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, DATA_W'($urandom), 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    master_valid = 1'b0;
    master_data  = '0;
    slave_ready  = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with master_valid high; outputs checked in the second cycle.
    do_reset(2);
    idle(1, 1'b0);

    // Streaming 1..8 with slave_ready held high.
    do_reset(1);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b1);
    idle(2, 1'b1);
    check("stream_cnt", 64'(xfer_cnt), 64'd8);

    // Backpressure: A, B fill the stage, C is held off until ready rises.
    step(1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b0, 1'b1, 32'hC, 1'b0);
    step(1'b0, 1'b1, 32'hC, 1'b0);
    check("bp_ready_low", 64'(master_ready), 64'd0);
    check("bp_hold_a",    64'(slave_data),   64'hA);
    step(1'b0, 1'b1, 32'hC, 1'b1);
    step(1'b0, 1'b0, 32'hDEAD, 1'b1);
    idle(4, 1'b1);

    // Simultaneous in/out while BUSY.
    step(1'b0, 1'b1, 32'h5, 1'b0);
    step(1'b0, 1'b1, 32'h6, 1'b1);
    check("sim_data", 64'(slave_data), 64'h6);
    check("sim_occ",  64'(occupancy),  64'd1);
    idle(2, 1'b1);

    // Mid-operation reset from FULL; stale beats must never resurface.
    step(1'b0, 1'b1, 32'h11, 1'b0);
    step(1'b0, 1'b1, 32'h22, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("full_occ", 64'(occupancy), 64'd2);
    do_reset(1);
    check("rst_empty", 64'(slave_valid), 64'd0);
    step(1'b0, 1'b1, 32'h33, 1'b0);  // first cycle after reset accepts
    idle(4, 1'b1);

    // Counter wrap: 17 transfers on a 4-bit counter leaves 1.
    do_reset(1);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, DATA_W'(32'h100 + i), 1'b1);
    idle(2, 1'b1);
    check("wrap_cnt", 64'(xfer_cnt), 64'd1);

    // Random traffic with occasional resets; data is random even when invalid.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           DATA_W'($urandom), ($urandom_range(0, 2) != 0));
    end
    idle(4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
